// File: rtl/rc5_pkg.sv
// Shared types and constants for the RC5-16 encryption sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rc5_pkg;
  localparam int W   = 16;
  localparam int LGW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_A,
    S_PRE_B,
    S_HALF_A,
    S_HALF_B,
    S_DONE
  } rc5_state_t;

  // Number of round-key words the key table must hold for a given round count.
  function automatic int key_depth(input int rounds);
    return 2 * rounds + 2;
  endfunction
endpackage

// File: rtl/rotl.sv
// Combinational left-rotate of a W-bit word by n_i modulo W.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module rotl #(
  parameter int W   = 16,
  parameter int LGW = 4
) (
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] n_i,
  output logic [W-1:0] data_o
);
  logic [LGW-1:0] w_amt;
  logic [2*W-1:0] w_dbl;
  logic           w_unused_hi;

  // Only the low LGW bits matter: rotating by W (or any multiple) is identity.
  always_comb begin
    w_amt       = n_i[LGW-1:0];
    w_unused_hi = ^n_i[W-1:LGW];
    w_dbl       = {data_i, data_i} << w_amt;
    data_o      = w_dbl[2*W-1:W];
  end
endmodule

// File: rtl/rc5_enc_ctrl.sv
// Iterative RC5-16 encryptor: sequences S[0..2R+1] reads, one shared rotator.
// Latency: accept in cycle 0 -> out_valid_o first high in cycle 2*ROUNDS+3.
// Backpressure: ciphertext held in DONE until out_ready_i; no accept outside IDLE.
module rc5_enc_ctrl
  import rc5_pkg::*;
#(
  parameter int ROUNDS = 12,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [W-1:0]      a_i,
  input  logic [W-1:0]      b_i,
  output logic [ADDR_W-1:0] skey_addr_o,
  input  logic [W-1:0]      skey_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [W-1:0]      a_o,
  output logic [W-1:0]      b_o,
  output logic              busy_o
);
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS);

  rc5_state_t       r_state;
  rc5_state_t       w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [CNT_W-1:0] r_i;

  logic [W-1:0]      w_rot_data;
  logic [LGW-1:0]    w_rot_amt;
  logic [W-1:0]      w_rot_n;
  logic [W-1:0]      w_rot_out;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_rdy;
  logic              w_out_vld;

  // Next-state, key address (one cycle ahead of use) and rotator operand select.
  always_comb begin
    w_next     = r_state;
    w_addr     = '0;
    w_in_rdy   = 1'b0;
    w_out_vld  = 1'b0;
    w_rot_data = '0;
    w_rot_amt  = '0;
    case (r_state)
      S_IDLE: begin
        w_in_rdy = 1'b1;
        if (in_valid_i) w_next = S_PRE_A;
      end
      S_PRE_A: begin
        w_addr = ADDR_W'(1);
        w_next = S_PRE_B;
      end
      S_PRE_B: begin
        w_addr = ADDR_W'(2);
        w_next = S_HALF_A;
      end
      S_HALF_A: begin
        w_rot_data = r_a ^ r_b;
        w_rot_amt  = r_b[LGW-1:0];
        w_addr     = ADDR_W'({r_i, 1'b1});
        w_next     = S_HALF_B;
      end
      S_HALF_B: begin
        w_rot_data = r_b ^ r_a;
        w_rot_amt  = r_a[LGW-1:0];
        if (r_i == LAST_RND) begin
          w_next = S_DONE;
        end else begin
          w_addr = ADDR_W'({r_i, 1'b0}) + ADDR_W'(2);
          w_next = S_HALF_A;
        end
      end
      S_DONE: begin
        w_out_vld = 1'b1;
        if (out_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_rot_n = {{(W-LGW){1'b0}}, w_rot_amt};

  rotl #(.W(W), .LGW(LGW)) ROTL (
    .data_i (w_rot_data),
    .n_i    (w_rot_n),
    .data_o (w_rot_out)
  );

  // State register and A/B/round datapath; key data arrives for the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_i     <= CNT_W'(1);
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_a <= a_i;
            r_b <= b_i;
          end
        end
        S_PRE_A: r_a <= r_a + skey_i;
        S_PRE_B: begin
          r_b <= r_b + skey_i;
          r_i <= CNT_W'(1);
        end
        S_HALF_A: r_a <= w_rot_out + skey_i;
        S_HALF_B: begin
          r_b <= w_rot_out + skey_i;
          if (r_i != LAST_RND) r_i <= r_i + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = w_in_rdy;
  assign out_valid_o = w_out_vld;
  assign skey_addr_o = w_addr;
  assign busy_o      = (r_state != S_IDLE);
  assign a_o         = w_out_vld ? r_a : '0;
  assign b_o         = w_out_vld ? r_b : '0;
endmodule

// File: tb/tb_rc5_enc_ctrl.sv
// Bench for rc5_enc_ctrl: two instances (ROUNDS=1 and ROUNDS=12) with key RAMs.
// Latency: checked against 2*R+3 per block.
// Backpressure: out_ready_i held low in DONE while new input is offered.
module tb_rc5_enc_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus-side signals, index 0 -> ROUNDS=1, index 1 -> ROUNDS=12
  logic        rst_t      [2];
  logic        in_valid_t [2];
  logic        out_ready_t[2];
  logic [15:0] a_in       [2];
  logic [15:0] b_in       [2];
  logic [15:0] skey_t     [2];
  logic [15:0] key_mem    [2][64];
  int          rounds     [2];

  logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [5:0]  addr0, addr1;
  logic [15:0] a_out0, a_out1, b_out0, b_out1;

  rc5_enc_ctrl #(.ROUNDS(1), .ADDR_W(6)) dut0 (
    .clk(clk), .rst(rst_t[0]), .in_valid_i(in_valid_t[0]), .in_ready_o(in_ready0),
    .a_i(a_in[0]), .b_i(b_in[0]), .skey_addr_o(addr0), .skey_i(skey_t[0]),
    .out_valid_o(out_valid0), .out_ready_i(out_ready_t[0]), .a_o(a_out0), .b_o(b_out0),
    .busy_o(busy0)
  );

  rc5_enc_ctrl #(.ROUNDS(12), .ADDR_W(6)) dut1 (
    .clk(clk), .rst(rst_t[1]), .in_valid_i(in_valid_t[1]), .in_ready_o(in_ready1),
    .a_i(a_in[1]), .b_i(b_in[1]), .skey_addr_o(addr1), .skey_i(skey_t[1]),
    .out_valid_o(out_valid1), .out_ready_i(out_ready_t[1]), .a_o(a_out1), .b_o(b_out1),
    .busy_o(busy1)
  );

  // Synchronous key tables: data for the address presented one cycle earlier
  always @(posedge clk) begin
    skey_t[0] <= key_mem[0][addr0];
    skey_t[1] <= key_mem[1][addr1];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference RC5-16 straight from the algorithm definition
  function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
    int s;
    s = n % 16;
    if (s == 0) return x;
    return (x << s) | (x >> (16 - s));
  endfunction

  function automatic logic [31:0] rc5(input int d, input logic [15:0] a0, input logic [15:0] b0);
    logic [15:0] A, B;
    A = a0 + key_mem[d][0];
    B = b0 + key_mem[d][1];
    for (int i = 1; i <= rounds[d]; i++) begin
      A = rotl16(A ^ B, int'(B)) + key_mem[d][2*i];
      B = rotl16(B ^ A, int'(A)) + key_mem[d][2*i+1];
    end
    return {A, B};
  endfunction

  // Transaction-level model: 0 = idle, 1 = computing (k cycles since accept), 2 = holding result
  int          m_st[2];
  int          m_k [2];
  logic [31:0] m_ct[2];
  bit          chk_en = 0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_t[d]) begin
        m_st[d] = 0;
        m_k[d]  = 0;
      end else begin
        case (m_st[d])
          0: if (in_valid_t[d]) begin
               m_ct[d] = rc5(d, a_in[d], b_in[d]);
               m_st[d] = 1;
               m_k[d]  = 1;
             end
          1: if (m_k[d] == 2*rounds[d] + 2) m_st[d] = 2;
             else m_k[d] = m_k[d] + 1;
          default: if (out_ready_t[d]) m_st[d] = 0;
        endcase
      end
    end
  end

  task automatic check_dut(input int d, input logic rdy, input logic vld, input logic bsy,
                           input logic [5:0] ad, input logic [15:0] ao, input logic [15:0] bo);
    string p;
    p = (d == 0) ? "r1" : "r12";
    chk({p, "_in_ready"},  {31'd0, rdy}, {31'd0, m_st[d] == 0});
    chk({p, "_out_valid"}, {31'd0, vld}, {31'd0, m_st[d] == 2});
    chk({p, "_busy"},      {31'd0, bsy}, {31'd0, m_st[d] != 0});
    chk({p, "_a_o"}, {16'd0, ao}, (m_st[d] == 2) ? {16'd0, m_ct[d][31:16]} : 32'd0);
    chk({p, "_b_o"}, {16'd0, bo}, (m_st[d] == 2) ? {16'd0, m_ct[d][15:0]}  : 32'd0);
    if (m_st[d] == 0)
      chk({p, "_addr_idle"}, {26'd0, ad}, 32'd0);
    else if (m_st[d] == 1)
      chk({p, "_addr_run"}, {26'd0, ad}, (m_k[d] <= 2*rounds[d] + 1) ? m_k[d] : 32'd0);
  endtask

  // Per-cycle compare against the model, on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, in_ready0, out_valid0, busy0, addr0, a_out0, b_out0);
      check_dut(1, in_ready1, out_valid1, busy1, addr1, a_out1, b_out1);
    end
  end

  function automatic logic gvld(input int d);  return (d == 0) ? out_valid0 : out_valid1; endfunction
  function automatic logic grdy(input int d);  return (d == 0) ? in_ready0  : in_ready1;  endfunction
  function automatic logic gbsy(input int d);  return (d == 0) ? busy0      : busy1;      endfunction
  function automatic logic [5:0]  gaddr(input int d); return (d == 0) ? addr0  : addr1;  endfunction
  function automatic logic [15:0] ga(input int d);    return (d == 0) ? a_out0 : a_out1; endfunction
  function automatic logic [15:0] gb(input int d);    return (d == 0) ? b_out0 : b_out1; endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ahist[4];

  // Send one block, wait for ciphertext, optionally stall the consumer, then drain.
  task automatic run_block(input int d, input logic [15:0] a, input logic [15:0] b, input int hold,
                           output int lat, output logic [15:0] ca, output logic [15:0] cb);
    int t0, j;
    in_valid_t[d] = 1'b1;
    a_in[d] = a;
    b_in[d] = b;
    t0 = cyc;
    j = 0;
    lat = -1;
    ca = '0;
    cb = '0;
    while (j < 200) begin
      if (j < 4) ahist[j] = gaddr(d);
      if (gvld(d)) break;
      step();
      in_valid_t[d] = 1'b0;
      a_in[d] = 16'hDEAD;
      b_in[d] = 16'hBEEF;
      j++;
    end
    if (!gvld(d)) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
    end else begin
      lat = cyc - t0;
      ca = ga(d);
      cb = gb(d);
      for (int h = 0; h < hold; h++) begin
        in_valid_t[d] = 1'b1;
        a_in[d] = 16'hFFFF;
        b_in[d] = 16'h5555;
        step();
        chk("hold_in_ready", {31'd0, grdy(d)}, 32'd0);
        chk("hold_a_stable", {16'd0, ga(d)}, {16'd0, ca});
      end
      out_ready_t[d] = 1'b1;
      step();
      out_ready_t[d] = 1'b0;
      in_valid_t[d]  = 1'b0;
      chk("release_idle", {31'd0, grdy(d)}, 32'd1);
      chk("release_vld",  {31'd0, gvld(d)}, 32'd0);
    end
  endtask

  int          lat;
  logic [15:0] ca, cb;

  initial begin
    rounds[0] = 1;
    rounds[1] = 12;
    for (int d = 0; d < 2; d++) begin
      rst_t[d] = 1'b1;
      in_valid_t[d] = 1'b0;
      out_ready_t[d] = 1'b0;
      a_in[d] = '0;
      b_in[d] = '0;
      for (int k = 0; k < 64; k++) key_mem[d][k] = '0;
    end
    for (int k = 0; k < 26; k++) key_mem[1][k] = 16'(16'hB7E1 + k * 16'h9E37);

    repeat (2) @(posedge clk);
    #1;
    rst_t[0] = 1'b0;
    rst_t[1] = 1'b0;
    chk_en = 1;
    chk("reset_in_ready",  {31'd0, in_ready0},  32'd1);
    chk("reset_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("reset_busy",      {31'd0, busy0},      32'd0);
    chk("reset_addr",      {26'd0, addr0},      32'd0);
    chk("reset12_in_ready", {31'd0, in_ready1}, 32'd1);
    chk("reset12_busy",     {31'd0, busy1},     32'd0);

    // Basic ROUNDS=1 block
    key_mem[0][0] = 16'd1;
    key_mem[0][1] = 16'd2;
    key_mem[0][2] = 16'd3;
    key_mem[0][3] = 16'd4;
    chk("model_basic", rc5(0, 16'h0001, 16'h0000), 32'h0003_000C);
    run_block(0, 16'h0001, 16'h0000, 0, lat, ca, cb);
    chk("basic_latency", lat, 32'd5);
    chk("basic_a", {16'd0, ca}, 32'h0003);
    chk("basic_b", {16'd0, cb}, 32'h000C);
    for (int k = 0; k < 4; k++) chk("basic_addr_seq", {26'd0, ahist[k]}, k);

    // Rotation wrap-around
    for (int k = 0; k < 4; k++) key_mem[0][k] = '0;
    chk("model_wrap", rc5(0, 16'h8000, 16'h0011), 32'h0023_0190);
    run_block(0, 16'h8000, 16'h0011, 0, lat, ca, cb);
    chk("wrap_a", {16'd0, ca}, 32'h0023);
    chk("wrap_b", {16'd0, cb}, 32'h0190);

    // Zero rotation amount from B[3:0]
    run_block(0, 16'h1234, 16'h0010, 0, lat, ca, cb);
    chk("zrot_a", {16'd0, ca}, 32'h1224);
    chk("zrot_b", {16'd0, cb}, 32'h2341);
    chk("zrot_latency", lat, 32'd5);

    // Backpressure: 5 stalled cycles with new input offered
    key_mem[0][0] = 16'd1;
    key_mem[0][1] = 16'd2;
    key_mem[0][2] = 16'd3;
    key_mem[0][3] = 16'd4;
    run_block(0, 16'h0001, 16'h0000, 5, lat, ca, cb);
    chk("bp_a", {16'd0, ca}, 32'h0003);
    step();
    chk("bp_no_accept", {31'd0, busy0}, 32'd0);

    // Mid-operation reset on the ROUNDS=12 instance at HALF_B, i=4 (cycle 10)
    in_valid_t[1] = 1'b1;
    a_in[1] = 16'h0F0F;
    b_in[1] = 16'h1357;
    step();
    in_valid_t[1] = 1'b0;
    repeat (9) step();
    chk("mid_addr_halfb4", {26'd0, addr1}, 32'd10);
    rst_t[1] = 1'b1;
    step();
    rst_t[1] = 1'b0;
    chk("mid_rst_in_ready", {31'd0, in_ready1},  32'd1);
    chk("mid_rst_busy",     {31'd0, busy1},      32'd0);
    chk("mid_rst_valid",    {31'd0, out_valid1}, 32'd0);
    chk("mid_rst_addr",     {26'd0, addr1},      32'd0);
    repeat (3) step();
    run_block(1, 16'hA5A5, 16'h3C3C, 2, lat, ca, cb);
    chk("r12_latency", lat, 32'd27);
    chk("r12_ct", {ca, cb}, rc5(1, 16'hA5A5, 16'h3C3C));

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rc5_enc_ctrl.md
Name: rc5_enc_ctrl

Overview:
Iterative RC5-16 encryption sequencer. Accepts one 32-bit plaintext block (A,B) over a valid/ready handshake and reads round keys S[0..2R+1] from an external synchronous key table. It time-shares a single internal rotl instance across both half-rounds and returns the ciphertext block over a second valid/ready handshake. Sits between the host block interface and the key-schedule RAM.

Parameters:
W, 16, word width (fixed at 16; rotation amount is 4 bits)
ROUNDS, 12, number of RC5 rounds R, legal range 1..31
ADDR_W, 6, key-table address width; must satisfy 2^ADDR_W >= 2*ROUNDS+2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid_i  in  1  plaintext valid
in_ready_o  out  1  plaintext accepted when in_valid_i & in_ready_o
a_i  in  W  plaintext word A
b_i  in  W  plaintext word B
skey_addr_o  out  ADDR_W  key-table read address
skey_i  in  W  key-table data, valid the cycle after skey_addr_o is presented
out_valid_o  out  1  ciphertext valid
out_ready_i  in  1  ciphertext consumed when out_valid_o & out_ready_i
a_o  out  W  ciphertext word A
b_o  out  W  ciphertext word B
busy_o  out  1  high in every state except IDLE

Behaviour:
- Clocking: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE, A=B=0, round counter=1, out_valid_o=0, in_ready_o=1, busy_o=0, skey_addr_o=0.
- States: IDLE, PRE_A, PRE_B, HALF_A, HALF_B, DONE.
- IDLE: in_ready_o=1, skey_addr_o=0. On handshake, latch A<=a_i, B<=b_i, and go to PRE_A.
- PRE_A: A<=A+skey_i (S[0]); skey_addr_o=1; go to PRE_B.
- PRE_B: B<=B+skey_i (S[1]); skey_addr_o=2; go to HALF_A, with i=1.
- HALF_A: A<=rotl(A^B, B[3:0])+skey_i (S[2i]); skey_addr_o=2i+1; go to HALF_B.
- HALF_B: B<=rotl(B^A, A[3:0])+skey_i (S[2i+1]). A here is the value updated by HALF_A.
  - If i==ROUNDS, go to DONE.
  - Otherwise skey_addr_o=2i+2, i<=i+1, and go to HALF_A.
- DONE: out_valid_o=1, a_o=A, b_o=B, held stable until out_ready_i. On handshake, go to IDLE.
  - In the same cycle, in_ready_o=0; no back-to-back accept from DONE.
- Address timing: skey_addr_o is a registered-state decode. The address driven in cycle k returns data in cycle k+1.
- In HALF_B with i==ROUNDS, skey_addr_o=0 (don't-care, but deterministic).
- Arithmetic: all additions are mod 2^16; carries are dropped.
- rotl usage: data_i=operand; n_i={12'b0, amt[3:0]}, zero-extended by the controller.
  - Amount 0 or 16 passes data through unchanged.
  - Outside HALF_A/HALF_B, rotl inputs are driven 0.
- Latency: handshake in cycle 0 gives out_valid_o first high in cycle 2*ROUNDS+3 (27 at default).
- Outputs: a_o and b_o are zero whenever out_valid_o=0.
- in_valid_i is ignored outside IDLE; a_i and b_i need only be stable in the handshake cycle.
- Reset mid-operation: return to IDLE the next edge. The in-flight block is discarded and no out_valid_o pulse occurs.
- out_ready_i high while out_valid_o is low: no effect.

Decomposition:
- Package rc5_pkg holds:
  - W=16, LGW=4
  - the state enum rc5_state_t
  - a function computing the key-table depth T=2*ROUNDS+2
- Sub-module: existing rotl, instantiated once (instance ROTL). No other sub-modules.

Test Plan:
- Reset state: after rst, check in_ready_o=1, out_valid_o=0, busy_o=0, skey_addr_o=0.
- Basic ROUNDS=1 block: S={1,2,3,4}, A=0x0001, B=0x0000 -> a_o=0x0003, b_o=0x000C, out_valid_o in cycle 5.
  - skey_addr_o sequence over cycles 0..3 is 0,1,2,3.
- Rotation wrap, ROUNDS=1, S all 0, A=0x8000, B=0x0011 -> a_o=0x0023, b_o=0x0190.
- Zero-rotation mask, ROUNDS=1, S all 0, A=0x1234, B=0x0010 -> a_o=0x1224, b_o=0x2341. B[3:0]=0, so the upper bits of the amount are ignored.
- Backpressure: hold out_ready_i=0 for 5 cycles after out_valid_o rises.
  - Outputs stay stable; in_ready_o=0 and new in_valid_i is ignored.
  - Releasing out_ready_i gives IDLE the next cycle.
- Mid-operation reset at default ROUNDS: assert rst in HALF_B with i=4.
  - The next cycle shows IDLE reset values.
  - A new block then completes after exactly 27 cycles, with no stale pulse.
